// File: rtl/alu_pkg.sv
// Shared ALU definitions: shift-kind encodings and the shift sequencer state type.
package alu_pkg;

    // ALUfun shift encodings; bit 1 alone selects the arithmetic right shift
    localparam logic [1:0] SH_SLL = 2'b00;
    localparam logic [1:0] SH_SRL = 2'b01;
    localparam logic [1:0] SH_SRA = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SHIFT2 = 2'b01,
        SHIFT1 = 2'b10,
        DONE   = 2'b11
    } shseq_state_t;

endpackage

// File: rtl/shift_seq_step.sv
// One combinational shift step of 1 or 2 bit positions for SLL / SRL / SRA.
module shift_step
    import alu_pkg::*;
(
    input  logic [31:0] d,
    input  logic        two,
    input  logic [1:0]  ALUfun,
    output logic [31:0] q
);

    // SRA when bit 1 is set (10 and 11 both), otherwise SRL / SLL by bit 0
    always_comb begin
        q = d;
        if (ALUfun[1]) begin
            q = two ? {{2{d[31]}}, d[31:2]} : {d[31], d[31:1]};
        end else if (ALUfun == SH_SRL) begin
            q = two ? {2'b00, d[31:2]} : {1'b0, d[31:1]};
        end else begin
            q = two ? {d[29:0], 2'b00} : {d[30:0], 1'b0};
        end
    end

endmodule

// File: rtl/shift_seq.sv
// Multi-cycle shift sequencer: repeats a 2-bit step shamt[4:1] times, then a
// 1-bit step if shamt is odd, and pulses done with the result held in y.
module shift_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] B,
    input  logic [SHW-1:0]   shamt,
    input  logic [1:0]       ALUfun,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y
);

    localparam int CNTW = SHW - 1;

    shseq_state_t    r_state;
    shseq_state_t    w_next;
    logic [WIDTH-1:0] r_y;
    logic [CNTW-1:0]  r_cnt;
    logic             r_odd;
    logic [1:0]       r_fun;
    logic [WIDTH-1:0] w_step;
    logic             w_two;
    logic             w_accept;

    assign w_accept = (r_state == IDLE) && start;
    assign w_two    = (r_state == SHIFT2);

    shift_step u_step (
        .d      (r_y),
        .two    (w_two),
        .ALUfun (r_fun),
        .q      (w_step)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state decode; IDLE looks at shamt directly since cnt/odd load on the same edge
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (shamt[SHW-1:1] != '0) w_next = SHIFT2;
                    else if (shamt[0])        w_next = SHIFT1;
                    else                      w_next = DONE;
                end
            end
            SHIFT2: begin
                if (r_cnt <= CNTW'(1)) w_next = r_odd ? SHIFT1 : DONE;
            end
            SHIFT1:  w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Working register, step counter and latched operands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y   <= '0;
            r_cnt <= '0;
            r_odd <= 1'b0;
            r_fun <= SH_SLL;
        end else if (w_accept) begin
            r_y   <= B;
            r_cnt <= shamt[SHW-1:1];
            r_odd <= shamt[0];
            r_fun <= ALUfun;
        end else if (r_state == SHIFT2) begin
            r_y <= w_step;
            if (r_cnt != '0) r_cnt <= r_cnt - CNTW'(1);
        end else if (r_state == SHIFT1) begin
            r_y <= w_step;
        end
    end

    // Outputs decoded from the state register only
    assign busy = (r_state != IDLE);
    assign done = (r_state == DONE);
    assign y    = r_y;

endmodule

// File: tb/tb_shift_seq.sv
// Self-checking bench for shift_seq: directed cases plus randomized requests
// checked against a shift-operator reference model.
module tb_shift_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] B;
    logic [4:0]  shamt;
    logic [1:0]  ALUfun;
    logic        busy;
    logic        done;
    logic [31:0] y;

    int n_pass = 0;
    int n_total = 0;

    shift_seq #(.WIDTH(32), .SHW(5)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .B      (B),
        .shamt  (shamt),
        .ALUfun (ALUfun),
        .busy   (busy),
        .done   (done),
        .y      (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model_y(input logic [31:0] b, input logic [4:0] sh,
                                            input logic [1:0] fn);
        logic signed [31:0] s;
        s = b;
        if (fn[1])      return s >>> sh;
        else if (fn[0]) return b >> sh;
        else            return b << sh;
    endfunction

    function automatic int model_lat(input logic [4:0] sh);
        return int'(sh) / 2 + int'(sh) % 2 + 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One request; pester re-pulses start with a different B while busy
    task automatic run(input string tag, input logic [31:0] b, input logic [4:0] sh,
                       input logic [1:0] fn, input bit pester);
        logic [31:0] exp_y, y_at_done;
        int lat, first, pulses;
        bit bsy_ok;
        exp_y = model_y(b, sh, fn);
        lat = model_lat(sh);
        first = 0; pulses = 0; bsy_ok = 1'b1; y_at_done = 'x;
        @(negedge clk);
        start = 1'b1; B = b; shamt = sh; ALUfun = fn;
        for (int e = 1; e <= lat + 3; e++) begin
            @(negedge clk);
            if (done) begin
                pulses++;
                if (first == 0) begin
                    first = e;
                    y_at_done = y;
                end
            end
            if ((e <= lat) != busy) bsy_ok = 1'b0;
            start = pester && (e == 1 || e == 2);
            if (pester) begin
                B = 32'hFFFF_FFFF;
                shamt = 5'd3;
            end
        end
        start = 1'b0;
        chk({tag, ".y"}, y_at_done, exp_y);
        chk({tag, ".lat"}, 32'(first), 32'(lat));
        chk({tag, ".pulses"}, 32'(pulses), 32'd1);
        chk({tag, ".busy"}, {31'd0, bsy_ok}, 32'd1);
        chk({tag, ".hold"}, y, exp_y);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; B = '0; shamt = '0; ALUfun = 2'b00;
        #1;
        chk("rst.y", y, 32'd0);
        chk("rst.busy", {31'd0, busy}, 32'd0);
        chk("rst.done", {31'd0, done}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run("sll5",    32'h0000_0001, 5'd5,  2'b00, 1'b0);
        run("sra31",   32'h8000_0000, 5'd31, 2'b11, 1'b0);
        run("sra31_10",32'h8000_0000, 5'd31, 2'b10, 1'b0);
        run("srl4",    32'h8000_0000, 5'd4,  2'b01, 1'b0);
        run("srl1",    32'h8000_0000, 5'd1,  2'b01, 1'b0);
        run("sh0",     32'hDEAD_BEEF, 5'd0,  2'b00, 1'b0);
        run("busyrej", 32'h0000_000F, 5'd8,  2'b00, 1'b1);
        run("after",   32'h1234_5678, 5'd3,  2'b01, 1'b0);

        // Reset in the middle of SHIFT2 aborts at once
        @(negedge clk);
        start = 1'b1; B = 32'hF0F0_1234; shamt = 5'd20; ALUfun = 2'b01;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst.y", y, 32'd0);
        chk("midrst.busy", {31'd0, busy}, 32'd0);
        chk("midrst.done", {31'd0, done}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            chk("midrst.nodone", {31'd0, done}, 32'd0);
        end
        run("postrst", 32'hF0F0_1234, 5'd20, 2'b11, 1'b0);

        for (int i = 0; i < 40; i++) begin
            run("rand", $urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/shift_seq.md
# shift_seq

Multi-cycle shift sequencer for the ALU shifter path. It accepts one shift request and repeats a single 2-bit shift step, plus one final 1-bit step for odd amounts, to compute any SLL, SRL or SRA by 0–31. This replaces a full 5-stage barrel shifter where area matters. It sits beside the ALU and is started by the control unit, which stalls until `done`.

## Interface
Parameters:
- `WIDTH`, 32, operand and result width; only 32 is supported.
- `SHW`, 5, shift-amount width.

Ports:
- `clk`, in, 1, single clock; all state is updated on the rising edge.
- `rst_n`, in, 1, asynchronous active-low reset.
- `start`, in, 1, request strobe; sampled only in IDLE.
- `B`, in, 32, operand; captured when `start` is accepted.
- `shamt`, in, 5, shift amount; captured when `start` is accepted.
- `ALUfun`, in, 2, shift kind: 00 = SLL, 01 = SRL, 1x = SRA; captured when `start` is accepted.
- `busy`, out, 1, high in every state except IDLE.
- `done`, out, 1, one-cycle pulse; `y` holds the final result in that cycle.
- `y`, out, 32, working/result register.

## Operation
- States: IDLE, SHIFT2, SHIFT1, DONE.
- IDLE:
  - On `start`, load `y <= B`, `cnt <= shamt[4:1]`, `odd <= shamt[0]`, and latch `ALUfun`.
  - Next state: SHIFT2 if `cnt` ≠ 0; else SHIFT1 if `odd`; else DONE.
- SHIFT2:
  - Each cycle, `y <= step2(y)` and `cnt <= cnt-1`.
  - When the pre-decrement `cnt` is 1, next state is SHIFT1 if `odd`, else DONE.
- SHIFT1: `y <= step1(y)`, then go to DONE.
- DONE: `done` = 1 for this one cycle, then return to IDLE. `y` is held.
- Step rules:
  - SLL shifts zeros in at the LSB.
  - SRL shifts zeros in at the MSB.
  - SRA replicates `y[31]`, sampled from the current `y`, into the vacated MSBs.
- ALUfun = 10 is treated as SRA (bit 1 dominates).
- `start` while `busy` is ignored; the latched operands are unaffected.
- `y` keeps its value in IDLE until the next accepted `start`. Mid-operation values are intermediate and carry no meaning outside DONE.
- `cnt` is 4 bits and never wraps; it is only decremented while non-zero.

## Timing
- Reset values (asynchronous, while `rst_n` = 0):
  - state = IDLE, `y` = 0, `cnt` = 0, `odd` = 0, `busy` = 0, `done` = 0.
- Reset asserted mid-operation aborts immediately: no `done` is produced and `y` = 0.
- Latency: `start` accepted at edge 0 → `done` high in the cycle after edge `L`, where L = shamt[4:1] + shamt[0] + 1.
  - Minimum is 1 cycle (shamt = 0).
  - Maximum is 17 cycles (shamt = 31).
- Throughput: a new `start` is accepted on the cycle after DONE (IDLE), so back-to-back requests cost L+1 cycles each.
- `busy` rises the cycle after acceptance and falls when DONE exits.
- `done` and `busy` are both high in DONE.
- Outputs are all registered or decoded from the state register; there is no combinational path from inputs to outputs.

## Structure
- Shared package `alu_pkg` holds:
  - ALUfun shift encodings `SH_SLL` = 2'b00, `SH_SRL` = 2'b01, `SH_SRA` = 2'b11.
  - The state typedef `shseq_state_t`.
- One sub-module: `shift_step`, a combinational single step.
  - Inputs: `d[31:0]`, `two` (1 = shift by 2, 0 = shift by 1), `ALUfun`.
  - Output: `q[31:0]`.
  - Instantiated once; `two` is high in SHIFT2 and low in SHIFT1.

## Test plan
- SLL: B = 0x00000001, shamt = 5, ALUfun = 00 → `y` = 0x00000020. `done` in the cycle after edge 4 (2+1+1). `busy` high for cycles 1–4.
- SRA: B = 0x80000000, shamt = 31, ALUfun = 11 → `y` = 0xFFFFFFFF. `done` after edge 17. Repeat with ALUfun = 10 for the same result.
- SRL: B = 0x80000000, shamt = 4, ALUfun = 01 → `y` = 0x08000000, `done` after edge 3. With shamt = 1 → 0x40000000, `done` after edge 2.
- shamt = 0: B = 0xDEADBEEF → `y` = 0xDEADBEEF, `done` after edge 1, exactly one pulse.
- Busy rejection: start (B = 0x0000000F, SLL, 8). Pulse `start` again with B = 0xFFFFFFFF at cycles 2 and 3. Result is still 0x00000F00 with a single `done`, and the next `start` is accepted in IDLE.
- Reset: assert `rst_n` = 0 during SHIFT2 of a shamt = 20 request. `y` = 0, `busy` = 0 and `done` = 0 immediately; after release, a new request completes normally.
